// File: rtl/input_channel_dequeue_scoreboard_pkg.sv
// Shared control constants and types for the input-channel dequeue scoreboard.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package input_channel_dequeue_scoreboard_pkg;

  localparam int TIA_NUM_INPUT_CHANNELS        = 4;
  localparam int TIA_ICD_WIDTH                 = TIA_NUM_INPUT_CHANNELS;
  localparam int TIA_CHANNEL_BUFFER_FIFO_DEPTH = 4;
  localparam int TIA_MAX_IN_FLIGHT_DEQUEUES    = 2;

  // Occupancy must represent 0..DEPTH, pending must represent 0..MAX_IN_FLIGHT.
  localparam int TIA_CHANNEL_COUNT_WIDTH = $clog2(TIA_CHANNEL_BUFFER_FIFO_DEPTH + 1);
  localparam int TIA_PENDING_COUNT_WIDTH = $clog2(TIA_MAX_IN_FLIGHT_DEQUEUES + 1);

  typedef logic [TIA_CHANNEL_COUNT_WIDTH-1:0] channel_count_t;
  typedef logic [TIA_PENDING_COUNT_WIDTH-1:0] pending_count_t;

  // Larger of two widths; used to size the occupancy-vs-pending compare.
  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_channel_dequeue_scoreboard_if.sv
// Bundles the trigger/decode/buffer-status signals seen by the dequeue scoreboard.
// Latency: n/a (wiring only).
// Backpressure: none; the empty status itself is the stall signal to the trigger stage.
interface input_channel_dequeue_scoreboard_if
  import input_channel_dequeue_scoreboard_pkg::*;
#(
  parameter int NUM_CHANNELS = TIA_NUM_INPUT_CHANNELS,
  parameter int CNT_W        = TIA_CHANNEL_COUNT_WIDTH,
  parameter int PND_W        = TIA_PENDING_COUNT_WIDTH
);

  logic [NUM_CHANNELS*CNT_W-1:0] input_channel_counts;
  logic                          trigger_valid;
  logic [NUM_CHANNELS-1:0]       trigger_icd;
  logic                          commit_valid;
  logic [NUM_CHANNELS-1:0]       commit_icd;
  logic                          pipeline_flush;
  logic [NUM_CHANNELS-1:0]       effective_empty_status;
  logic [NUM_CHANNELS*PND_W-1:0] pending_dequeue_counts;
  logic                          scoreboard_error;

  // Pipeline side: drives trigger/commit/flush and buffer occupancy.
  modport master (
    output input_channel_counts, trigger_valid, trigger_icd,
           commit_valid, commit_icd, pipeline_flush,
    input  effective_empty_status, pending_dequeue_counts, scoreboard_error
  );

  // Scoreboard side.
  modport slave (
    input  input_channel_counts, trigger_valid, trigger_icd,
           commit_valid, commit_icd, pipeline_flush,
    output effective_empty_status, pending_dequeue_counts, scoreboard_error
  );

endinterface

// File: rtl/input_channel_dequeue_scoreboard_pending_counter.sv
// One channel's in-flight dequeue counter: saturating up/down with flush to zero.
// Latency: count updates one cycle after inc/dec/flush; error flag is combinational.
// Backpressure: none; over/underflow is flagged instead of blocked.
module input_channel_dequeue_scoreboard_pending_counter
  import input_channel_dequeue_scoreboard_pkg::*;
#(
  parameter int MAX_IN_FLIGHT = TIA_MAX_IN_FLIGHT_DEQUEUES,
  parameter int PND_W         = TIA_PENDING_COUNT_WIDTH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_flush,
  output logic [PND_W-1:0] o_count,
  output logic             o_error
);

  localparam logic [PND_W-1:0] MAX_CNT = PND_W'(MAX_IN_FLIGHT);

  logic [PND_W-1:0] r_count;
  logic             w_up;
  logic             w_down;
  logic             w_at_max;
  logic             w_at_zero;

  // Simultaneous inc and dec cancel; flush squashes both.
  assign w_up      = i_inc & ~i_dec & ~i_flush;
  assign w_down    = i_dec & ~i_inc & ~i_flush;
  assign w_at_max  = (r_count == MAX_CNT);
  assign w_at_zero = (r_count == '0);

  // Saturating counter: hold at the rails rather than wrapping.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_count <= '0;
    end else if (w_up && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end else if (w_down && !w_at_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  // Trying to move past either rail means an upstream accounting bug.
  assign o_error = (w_up & w_at_max) | (w_down & w_at_zero);

endmodule

// File: rtl/input_channel_dequeue_scoreboard.sv
// Per-channel scoreboard of dequeues triggered but not yet committed; yields effective empty.
// Latency: pending counts one cycle after trigger/commit; empty status combinational from them.
// Backpressure: a channel reads empty when occupancy <= in-flight dequeues or in-flight is full.
module input_channel_dequeue_scoreboard
  import input_channel_dequeue_scoreboard_pkg::*;
#(
  parameter int NUM_CHANNELS  = TIA_NUM_INPUT_CHANNELS,
  parameter int BUFFER_DEPTH  = TIA_CHANNEL_BUFFER_FIFO_DEPTH,
  parameter int MAX_IN_FLIGHT = TIA_MAX_IN_FLIGHT_DEQUEUES
) (
  input logic                              i_clock,
  input logic                              i_reset,
  input_channel_dequeue_scoreboard_if.slave sb
);

  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam int PND_W = $clog2(MAX_IN_FLIGHT + 1);
  localparam int CMP_W = max_width(CNT_W, PND_W);

  logic [NUM_CHANNELS-1:0][PND_W-1:0] w_pnd;
  logic [NUM_CHANNELS-1:0][PND_W-1:0] w_pnd_eff;
  logic [NUM_CHANNELS-1:0]            w_err;
  logic [NUM_CHANNELS-1:0]            w_empty;
  logic                               r_error;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic             w_inc;
    logic             w_dec;
    logic [CMP_W-1:0] w_cnt_ext;
    logic [CMP_W-1:0] w_pnd_ext;

    assign w_inc = sb.trigger_valid & sb.trigger_icd[c];
    assign w_dec = sb.commit_valid & sb.commit_icd[c];

    input_channel_dequeue_scoreboard_pending_counter #(
      .MAX_IN_FLIGHT (MAX_IN_FLIGHT),
      .PND_W         (PND_W)
    ) u_cnt (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_inc   (w_inc),
      .i_dec   (w_dec),
      .i_flush (sb.pipeline_flush),
      .o_count (w_pnd[c]),
      .o_error (w_err[c])
    );

    // Treat pending as zero while reset is held so empty tracks raw occupancy from the first cycle.
    assign w_pnd_eff[c] = i_reset ? '0 : w_pnd[c];

    assign w_cnt_ext = CMP_W'(sb.input_channel_counts[c*CNT_W +: CNT_W]);
    assign w_pnd_ext = CMP_W'(w_pnd_eff[c]);

    // Stall when every buffered item is already claimed, or the in-flight window is full.
    assign w_empty[c] = (w_cnt_ext <= w_pnd_ext) | (w_pnd_eff[c] == PND_W'(MAX_IN_FLIGHT));

    assign sb.pending_dequeue_counts[c*PND_W +: PND_W] = w_pnd_eff[c];
  end

  // Sticky error: any channel over/underflow latches until reset; flush does not clear it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_error <= 1'b0;
    end else if (|w_err) begin
      r_error <= 1'b1;
    end
  end

  assign sb.effective_empty_status = w_empty;
  assign sb.scoreboard_error       = r_error;

endmodule

// File: tb/tb_input_channel_dequeue_scoreboard.sv
// Directed self-checking bench for the input-channel dequeue scoreboard.
// Latency: checks pending one cycle after trigger/commit, empty same cycle as inputs.
// Backpressure: n/a.
module tb_input_channel_dequeue_scoreboard;

  logic clk;
  logic rst;

  int n_vec;
  int n_miss;

  input_channel_dequeue_scoreboard_if u_if ();

  input_channel_dequeue_scoreboard u_dut (
    .i_clock (clk),
    .i_reset (rst),
    .sb      (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
    u_if.input_channel_counts = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endtask

  task automatic drive(input logic tv, input logic [3:0] ti,
                       input logic cv, input logic [3:0] ci, input logic fl);
    u_if.trigger_valid  = tv;
    u_if.trigger_icd    = ti;
    u_if.commit_valid   = cv;
    u_if.commit_icd     = ci;
    u_if.pipeline_flush = fl;
  endtask

  function automatic int pnd(input int c);
    return int'(u_if.pending_dequeue_counts[c*2 +: 2]);
  endfunction

  initial begin
    n_vec  = 0;
    n_miss = 0;

    // 1. Reset with counts {ch0..ch3} = {0,1,2,3}
    rst = 1'b1;
    set_counts(0, 1, 2, 3);
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("empty_in_reset", int'(u_if.effective_empty_status), 4'b0001);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("empty_after_reset", int'(u_if.effective_empty_status), 4'b0001);
    chk("pending_after_reset", int'(u_if.pending_dequeue_counts), 0);
    chk("error_after_reset", int'(u_if.scoreboard_error), 0);

    // 2. ch1 count=2, two back-to-back triggers on ch1
    set_counts(0, 2, 2, 3);
    drive(1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0);
    step();
    chk("t2_pend1_a", pnd(1), 1);
    chk("t2_empty1_a", int'(u_if.effective_empty_status[1]), 0);
    step();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("t2_pend1_b", pnd(1), 2);
    chk("t2_empty_b", int'(u_if.effective_empty_status), 4'b0011);
    chk("t2_error", int'(u_if.scoreboard_error), 0);
    // Drain ch1: decode commits both; buffer occupancy follows
    drive(1'b0, 4'b0000, 1'b1, 4'b0010, 1'b0);
    step();
    set_counts(0, 1, 2, 3);
    step();
    set_counts(0, 0, 2, 3);
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("t2_drained", int'(u_if.pending_dequeue_counts), 0);

    // 3. ch0 count=1: trigger, then commit with count dropping to 0
    set_counts(1, 0, 2, 3);
    #1;
    chk("t3_empty0_pre", int'(u_if.effective_empty_status[0]), 0);
    drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0);
    step();
    drive(1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0);
    #1;
    chk("t3_pend0_a", pnd(0), 1);
    chk("t3_empty0_a", int'(u_if.effective_empty_status[0]), 1);
    step();
    set_counts(0, 0, 2, 3);
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("t3_pend0_b", pnd(0), 0);
    chk("t3_empty0_b", int'(u_if.effective_empty_status[0]), 1);

    // 4. ch2: same-cycle trigger+commit with pending2=1 holds
    drive(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0);
    step();
    chk("t4_pend2_a", pnd(2), 1);
    drive(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0);
    step();
    chk("t4_pend2_hold", pnd(2), 1);
    drive(1'b0, 4'b0000, 1'b1, 4'b0100, 1'b0);
    step();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("t4_pend2_c", pnd(2), 0);
    chk("t4_error", int'(u_if.scoreboard_error), 0);

    // 5. Build pending {ch0..ch3} = {2,1,0,1}, then flush with commit ch0
    set_counts(4, 4, 4, 4);
    drive(1'b1, 4'b1011, 1'b0, 4'b0000, 1'b0);
    step();
    drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0);
    step();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("t5_pend_bus", int'(u_if.pending_dequeue_counts), 8'h46);
    // ch0 count 4 > pending 2 but window is full -> empty; ch1/ch3 have room
    chk("t5_empty_sat", int'(u_if.effective_empty_status), 4'b0001);
    drive(1'b1, 4'b0100, 1'b1, 4'b0001, 1'b1);
    step();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("t5_flush_pend", int'(u_if.pending_dequeue_counts), 0);
    chk("t5_flush_error", int'(u_if.scoreboard_error), 0);

    // 6. Underflow on ch3 sets sticky error; flush keeps it; reset clears
    set_counts(0, 1, 2, 3);
    drive(1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0);
    step();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("t6_error_set", int'(u_if.scoreboard_error), 1);
    chk("t6_pend3_hold", pnd(3), 0);
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    step();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("t6_error_flush", int'(u_if.scoreboard_error), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t6_error_reset", int'(u_if.scoreboard_error), 0);

    // 7. Overflow on ch1: third trigger saturates at 2 and flags error
    set_counts(0, 4, 2, 3);
    drive(1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0);
    step();
    step();
    chk("t7_error_pre", int'(u_if.scoreboard_error), 0);
    step();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("t7_pend1_sat", pnd(1), 2);
    chk("t7_error_ovf", int'(u_if.scoreboard_error), 1);
    chk("t7_others", int'(u_if.pending_dequeue_counts & 8'hF3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
